// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencer: state encoding and default field geometry.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_PAUSE     = 2'd1,
    ST_ADJ_RUN   = 2'd2,
    ST_ADJ_PAUSE = 2'd3
  } state_e;

  localparam int DEF_MAX_VAL = 59;
  localparam int DEF_W       = 6;

endpackage

// File: rtl/mod_counter.sv
// One W-bit count field: increment with wrap at MAX_VAL, synchronous clear, carry flag at terminal value.
module mod_counter
  import stopwatch_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_W = W'(MAX_VAL);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment so a clear press never loses to a same-cycle tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == MAX_W) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == MAX_W);

endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch control: run/pause/adjust state, minute/second fields and the adjust-mode blink phase.
module stopwatch_sequencer
  import stopwatch_pkg::*;
#(
  parameter int MAX_VAL = DEF_MAX_VAL,
  parameter int W       = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_count,
  input  logic         tick_adj,
  input  logic         tick_blink,
  input  logic         pause_p,
  input  logic         clear_p,
  input  logic         adj,
  input  logic         sel,
  output logic [W-1:0] min,
  output logic [W-1:0] sec,
  output logic         blank_min,
  output logic         blank_sec,
  output logic         running
);

  state_e state_q, state_d;
  logic   phase_q, phase_d;
  logic   sel_q;

  logic   in_adj;
  logic   run_choice;
  logic   run_next;
  logic   sec_inc, min_inc;
  logic   sec_at_max;
  logic   min_at_max;

  assign in_adj     = (state_q == ST_ADJ_RUN) || (state_q == ST_ADJ_PAUSE);
  assign run_choice = (state_q == ST_RUN) || (state_q == ST_ADJ_RUN);

  // The run/pause choice and the adjust level are independent, so a pause press
  // and an adj edge in the same cycle both take effect.
  always_comb begin
    state_d  = state_q;
    run_next = run_choice ^ pause_p;
    case ({adj, run_next})
      2'b00:   state_d = ST_PAUSE;
      2'b01:   state_d = ST_RUN;
      2'b10:   state_d = ST_ADJ_PAUSE;
      default: state_d = ST_ADJ_RUN;
    endcase
  end

  // Phase only toggles while staying inside adjust; entry, exit and clear zero it.
  always_comb begin
    phase_d = 1'b0;
    if (in_adj && adj && !clear_p) begin
      phase_d = phase_q ^ tick_blink;
    end
  end

  always_comb begin
    sec_inc = 1'b0;
    min_inc = 1'b0;
    if (state_q == ST_RUN) begin
      sec_inc = tick_count;
      min_inc = tick_count && sec_at_max;
    end else if (in_adj) begin
      sec_inc = tick_adj && !sel;
      min_inc = tick_adj && sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_PAUSE;
      phase_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sel_q   <= sel;
    end
  end

  mod_counter #(.W(W), .MAX_VAL(MAX_VAL)) u_sec (
    .clk    (clk),
    .reset  (reset),
    .inc    (sec_inc),
    .clr    (clear_p),
    .cnt    (sec),
    .at_max (sec_at_max)
  );

  // The minutes field wraps by itself at MAX_VAL, which gives 59:59 -> 00:00.
  mod_counter #(.W(W), .MAX_VAL(MAX_VAL)) u_min (
    .clk    (clk),
    .reset  (reset),
    .inc    (min_inc),
    .clr    (clear_p),
    .cnt    (min),
    .at_max (min_at_max)
  );

  assign running   = (state_q == ST_RUN);
  assign blank_min = in_adj && sel_q && phase_q;
  assign blank_sec = in_adj && !sel_q && phase_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Self-checking bench for stopwatch_sequencer: vector table, directed corner sequences, random run vs. model.
module tb_stopwatch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_count, tick_adj, tick_blink, pause_p, clear_p, adj, sel;
  logic [5:0] min, sec;
  logic       blank_min, blank_sec, running;

  int total = 0;
  int bad   = 0;

  // Reference model: stopwatch time and mode flags, advanced with plain arithmetic.
  int m_min, m_sec;
  bit m_run, m_adjm, m_sel, m_phase;

  typedef struct {
    bit pp, cp, tc, ta, tb, a, s;
    int emin, esec;
    bit erun, ebm, ebs;
  } vec_t;

  vec_t vecs[10];

  stopwatch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .tick_count (tick_count),
    .tick_adj   (tick_adj),
    .tick_blink (tick_blink),
    .pause_p    (pause_p),
    .clear_p    (clear_p),
    .adj        (adj),
    .sel        (sel),
    .min        (min),
    .sec        (sec),
    .blank_min  (blank_min),
    .blank_sec  (blank_sec),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int emin, input int esec,
                       input bit erun, input bit ebm, input bit ebs);
    total++;
    if (min !== 6'(emin) || sec !== 6'(esec) || running !== erun ||
        blank_min !== ebm || blank_sec !== ebs) begin
      bad++;
      $display("FAIL %s: got %0d:%0d run=%b bm=%b bs=%b, want %0d:%0d run=%b bm=%b bs=%b",
               name, min, sec, running, blank_min, blank_sec, emin, esec, erun, ebm, ebs);
    end
  endtask

  task automatic model_reset();
    m_min = 0; m_sec = 0; m_run = 0; m_adjm = 0; m_sel = 0; m_phase = 0;
  endtask

  task automatic model_step(input bit pp, input bit cp, input bit tc, input bit ta,
                            input bit tb, input bit a, input bit s);
    int  t;
    bit  keep;
    keep = m_adjm && a && !cp;
    if (cp) begin
      m_min = 0; m_sec = 0;
    end else if (m_run && !m_adjm && tc) begin
      t = (m_min * 60 + m_sec + 1) % 3600;
      m_min = t / 60;
      m_sec = t % 60;
    end else if (m_adjm && ta) begin
      if (s) m_min = (m_min + 1) % 60;
      else   m_sec = (m_sec + 1) % 60;
    end
    m_phase = keep ? (m_phase ^ tb) : 1'b0;
    m_run   = m_run ^ pp;
    m_adjm  = a;
    m_sel   = s;
  endtask

  // One clock cycle: drive, clock, advance the model, compare.
  task automatic step(input bit pp, input bit cp, input bit tc, input bit ta,
                      input bit tb, input bit a, input bit s);
    pause_p = pp; clear_p = cp; tick_count = tc; tick_adj = ta; tick_blink = tb;
    adj = a; sel = s;
    @(posedge clk);
    #1;
    model_step(pp, cp, tc, ta, tb, a, s);
    pause_p = 0; clear_p = 0; tick_count = 0; tick_adj = 0; tick_blink = 0;
    check("model", m_min, m_sec, m_run && !m_adjm,
          m_adjm && m_sel && m_phase, m_adjm && !m_sel && m_phase);
  endtask

  task automatic do_reset();
    reset = 0;
    pause_p = 0; clear_p = 0; tick_count = 0; tick_adj = 0; tick_blink = 0;
    adj = 0; sel = 0;
    #23;
    check("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1;
    model_reset();
  endtask

  initial begin
    // pp cp tc ta tb a s : min sec run bm bs
    vecs[0] = '{1,0,0,0,0,0,0, 0,0,1,0,0};
    vecs[1] = '{0,0,1,0,0,0,0, 0,1,1,0,0};
    vecs[2] = '{0,0,1,0,0,1,0, 0,2,0,0,0};
    vecs[3] = '{0,0,0,1,0,1,1, 1,2,0,0,0};
    vecs[4] = '{0,0,0,0,1,1,1, 1,2,0,1,0};
    vecs[5] = '{0,0,0,0,0,1,0, 1,2,0,0,1};
    vecs[6] = '{0,0,1,1,0,1,0, 1,3,0,0,1};
    vecs[7] = '{1,0,0,0,0,0,0, 1,3,0,0,0};
    vecs[8] = '{0,0,1,0,0,0,0, 1,3,0,0,0};
    vecs[9] = '{0,1,0,1,0,0,0, 0,0,0,0,0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].pp, vecs[i].cp, vecs[i].tc, vecs[i].ta, vecs[i].tb, vecs[i].a, vecs[i].s);
      check($sformatf("vec%0d", i), vecs[i].emin, vecs[i].esec, vecs[i].erun,
            vecs[i].ebm, vecs[i].ebs);
    end

    // Start, then 61 seconds.
    do_reset();
    step(1,0,0,0,0,0,0);
    for (int i = 0; i < 61; i++) step(0,0,1,0,0,0,0);
    check("run61", 1, 1, 1, 0, 0);

    // Preload 59:58 through adjust, then roll over.
    step(0,1,0,0,0,0,0);
    step(0,0,0,0,0,1,1);
    for (int i = 0; i < 59; i++) step(0,0,0,1,0,1,1);
    for (int i = 0; i < 58; i++) step(0,0,0,1,0,1,0);
    step(0,0,0,0,0,0,0);
    check("preload", 59, 58, 1, 0, 0);
    step(0,0,1,0,0,0,0);
    check("5959", 59, 59, 1, 0, 0);
    step(0,0,1,0,0,0,0);
    check("wrap0000", 0, 0, 1, 0, 0);

    // Pause ignores ticks; tick coincident with resume is ignored too.
    for (int i = 0; i < 3; i++) step(0,0,1,0,0,0,0);
    step(1,0,0,0,0,0,0);
    for (int i = 0; i < 5; i++) step(0,0,1,1,1,0,0);
    check("paused", 0, 3, 0, 0, 0);
    step(1,0,1,0,0,0,0);
    check("resume", 0, 3, 1, 0, 0);

    // Adjust seconds: 60 adjust ticks wrap back, count ticks ignored.
    step(0,0,0,0,0,1,0);
    for (int i = 0; i < 60; i++) step(0,0,1,1,0,1,0);
    check("adj60", 0, 3, 0, 0, 0);

    // Blink on minutes, then leave adjust.
    step(0,0,0,0,0,1,1);
    step(0,0,0,0,1,1,1);
    check("blink1", 0, 3, 0, 1, 0);
    step(0,0,0,0,1,1,1);
    check("blink2", 0, 3, 0, 0, 0);
    step(0,0,0,0,1,1,1);
    check("blink3", 0, 3, 0, 1, 0);
    step(0,0,0,0,0,0,1);
    check("adjexit", 0, 3, 1, 0, 0);

    // 12:34 in RUN, clear beats tick, then asynchronous reset.
    step(0,1,0,0,0,0,0);
    step(0,0,0,0,0,1,1);
    for (int i = 0; i < 12; i++) step(0,0,0,1,0,1,1);
    for (int i = 0; i < 34; i++) step(0,0,0,1,0,1,0);
    step(0,0,0,0,0,0,0);
    check("at1234", 12, 34, 1, 0, 0);
    step(0,1,1,0,0,0,0);
    check("clear", 0, 0, 1, 0, 0);
    step(0,0,1,0,0,0,0);
    step(0,0,1,0,0,0,0);
    check("pre_rst", 0, 2, 1, 0, 0);
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    check("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1;
    model_reset();
    step(0,0,1,0,0,0,0);
    check("rst_pause", 0, 0, 0, 0, 0);

    // Random stimulus against the model.
    do_reset();
    begin
      bit a_lvl, s_lvl;
      a_lvl = 0; s_lvl = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(19) == 0) a_lvl = ~a_lvl;
        if ($urandom_range(9) == 0)  s_lvl = ~s_lvl;
        step($urandom_range(7) == 0, $urandom_range(63) == 0, $urandom_range(1) == 0,
             $urandom_range(2) == 0, $urandom_range(2) == 0, a_lvl, s_lvl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_sequencer.md
# stopwatch_sequencer

Sequencing controller for the lab stopwatch: owns the minutes/seconds count registers and decides, every cycle, whether they count, hold, get adjusted or clear. Sits between the clock divider and debouncers (which supply single-cycle tick enables and clean button signals) and the seven-segment display driver (which consumes `min`, `sec` and the per-field blank flags). All logic runs in one clock domain. Divided clocks are consumed only as enables, never as clocks.

## Interface
- `MAX_VAL`, default 59: terminal value of both fields; wrap to 0 after it.
- `W`, default 6: width of each count field.
- `clk`  in  1  system clock; only clock in the block.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `tick_count`  in  1  1 Hz enable, one `clk` cycle wide.
- `tick_adj`  in  1  2 Hz enable, one cycle wide.
- `tick_blink`  in  1  blink-rate enable, one cycle wide.
- `pause_p`  in  1  debounced pause press, one-cycle pulse.
- `clear_p`  in  1  debounced clear press, one-cycle pulse.
- `adj`  in  1  debounced level; 1 = adjust mode.
- `sel`  in  1  debounced level; 0 = adjust seconds, 1 = adjust minutes.
- `min`  out  W  minutes count, registered.
- `sec`  out  W  seconds count, registered.
- `blank_min`  out  1  display must blank the minutes digits.
- `blank_sec`  out  1  display must blank the seconds digits.
- `running`  out  1  1 when in RUN.

## Operation
- There are 4 states: RUN, PAUSE, ADJ_RUN and ADJ_PAUSE. The ADJ_* states remember the run/pause choice to use on exit.
- Pause toggle (`pause_p`):
  - RUN↔PAUSE.
  - ADJ_RUN↔ADJ_PAUSE.
- Entering and leaving adjust:
  - `adj`=1 moves RUN→ADJ_RUN and PAUSE→ADJ_PAUSE.
  - `adj`=0 moves ADJ_RUN→RUN and ADJ_PAUSE→PAUSE.
  - If `pause_p` and an `adj` change occur in the same cycle, both apply: PAUSE with `adj`↑ and `pause_p` goes to ADJ_RUN.
- RUN, on `tick_count`:
  - `sec` increments.
  - When `sec`=MAX_VAL, `sec`→0 and `min` increments.
  - When `min`=`sec`=MAX_VAL, both go to 0 (59:59→00:00).
- PAUSE: counts hold and all ticks are ignored.
- ADJ_*, on `tick_adj`:
  - The selected field (by `sel`) increments and wraps MAX_VAL→0 with no carry.
  - The other field holds.
  - `tick_count` is ignored.
- Blink:
  - A 1-bit `phase` toggles on each `tick_blink` while in ADJ_*.
  - `phase` is forced to 0 on entry to ADJ_* and while outside ADJ_*.
  - `blank_min` = ADJ_* & `sel` & `phase`.
  - `blank_sec` = ADJ_* & !`sel` & `phase`.
- Clear (`clear_p`):
  - `min`, `sec` and `phase` go to 0. State is unchanged.
  - Clear has priority over any increment in the same cycle.
- Count updates decode the state held before that cycle's edge. A tick in the same cycle as a transition is handled by the old state.

## Timing
- Reset (`reset`=0, asynchronous):
  - State = PAUSE.
  - `min`=0, `sec`=0, `phase`=0.
  - `blank_min`=0, `blank_sec`=0, `running`=0.
- Reset deassertion takes effect at the first `clk` edge with `reset`=1.
- If reset is asserted mid-count, counts return to 00:00 immediately, without waiting for a clock edge.
- Latency: a tick or pulse in cycle N is visible on the outputs after the edge ending cycle N (1 cycle).
- All outputs are registered or decoded only from registers; there is no combinational input→output path.
- Input pulses longer than one cycle are counted once per cycle asserted; producing one-cycle pulses is the upstream's responsibility.
- `sel` changes take effect on the next `tick_adj` and on blank flags 1 cycle later.

## Structure
- Shared package `stopwatch_pkg`:
  - state encoding constants ST_RUN, ST_PAUSE, ST_ADJ_RUN, ST_ADJ_PAUSE (2 bits);
  - default MAX_VAL and W.
- Sub-module `mod_counter`: W-bit counter with `inc`, `clr` and wrap-at-MAX_VAL. It outputs `at_max`, the carry to the next field. It is instantiated twice (sec, min).
- The state register and blink phase live in the top module.

## Test plan
- Reset, release, `pause_p`, then 61 `tick_count` → `running`=1, `min`=1, `sec`=1.
- Preload 59:58 via adjust, return to RUN, 2 `tick_count` → 59:59, then 00:00.
- PAUSE, 5 `tick_count` → counts unchanged. Then `pause_p` with `tick_count` in the same cycle → tick ignored, `running`=1 on the next cycle.
- RUN, set `adj`=1 and `sel`=0, 60 `tick_adj` → `sec` wraps to its start value, `min` unchanged. `tick_count` is ignored throughout.
- In ADJ_*, with `sel`=1, 3 `tick_blink` → `blank_min` shows 1,0,1 and `blank_sec`=0. Drop `adj` → both blank flags go to 0 in 1 cycle.
- At 12:34 in RUN: assert `clear_p` with `tick_count` in the same cycle → 00:00 and still RUN. Then pull `reset` low mid-cycle → outputs go to 0 immediately and the state is PAUSE.
